// File: rtl/digit_buffer_pkg.sv
// digit_pkg: shared definitions for the keypad digit-entry path.
//   overflow_mode_e  - policy when a digit arrives while the buffer is full
//   DEFAULT_DIGIT_W  - digit code width shared by the keypad decoder,
//                      digit_buffer and the display driver
package digit_pkg;

    typedef enum logic {
        OVF_REJECT = 1'b0,  // drop the new digit, keep contents
        OVF_SHIFT  = 1'b1   // discard the oldest digit, take the new one
    } overflow_mode_e;

    localparam int DEFAULT_DIGIT_W = 4;

endpackage

// File: rtl/digit_buffer_edge_detect.sv
// edge_detect: 1-bit rising-edge detector with synchronous active-high reset.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; clears the edge history
//   level  in   level-sensitive strobe
//   rise   out  high in the cycle where level is high and was low last cycle
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    // Combinational so the edge is consumed on the same clock that first
    // samples the strobe high.
    assign rise = level & ~prev;

endmodule

// File: rtl/digit_buffer.sv
// digit_buffer: right-justified keypad digit-entry buffer.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   digit       in   keypad digit code, sampled on a valid rising edge
//   valid       in   digit strobe (level, edge-qualified internally)
//   back        in   backspace strobe (level, edge-qualified internally)
//   clear       in   empties the buffer every cycle it is high
//   out         out  packed digits, newest in the least significant slot
//   digit_mask  out  thermometer mask of occupied slots
//   count       out  number of occupied digits
//   full        out  count == DIGITS
//   accept      out  one-cycle pulse: a digit was stored
//   overflow    out  one-cycle pulse: a digit arrived while full
module digit_buffer
    import digit_pkg::*;
#(
    parameter int             DIGITS        = 4,
    parameter int             DIGIT_W       = DEFAULT_DIGIT_W,
    parameter overflow_mode_e OVERFLOW_MODE = OVF_REJECT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          valid,
    input  logic                          back,
    input  logic                          clear,
    output logic [DIGITS*DIGIT_W-1:0]     out,
    output logic [DIGITS-1:0]             digit_mask,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic                          full,
    output logic                          accept,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int LOW_W = (DIGITS - 1) * DIGIT_W;

    logic valid_rise;
    logic back_rise;

    // Edge history keeps running through clear; only reset wipes it.
    edge_detect u_valid_edge (
        .clk   (clk),
        .reset (reset),
        .level (valid),
        .rise  (valid_rise)
    );

    edge_detect u_back_edge (
        .clk   (clk),
        .reset (reset),
        .level (back),
        .rise  (back_rise)
    );

    // Priority: reset > clear > back edge > valid edge. A lower-priority edge
    // in the same cycle is simply not acted on; its edge register still
    // advances, so it is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            count    <= '0;
            accept   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            accept   <= 1'b0;
            overflow <= 1'b0;
            if (clear) begin
                out   <= '0;
                count <= '0;
            end else if (back_rise) begin
                // Empty buffer: no-op, no pulses.
                if (count != '0) begin
                    out   <= out >> DIGIT_W;
                    count <= count - CNT_W'(1);
                end
            end else if (valid_rise) begin
                if (!full) begin
                    out    <= {out[LOW_W-1:0], digit};
                    count  <= count + CNT_W'(1);
                    accept <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                    // Shift mode drops the oldest digit off the top; count
                    // stays at DIGITS.
                    if (OVERFLOW_MODE == OVF_SHIFT) begin
                        out    <= {out[LOW_W-1:0], digit};
                        accept <= 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        digit_mask = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_mask[i] = (CNT_W'(i) < count);
        end
    end

    assign full = (count == CNT_W'(DIGITS));

endmodule

// File: tb/tb_digit_buffer.sv
// Self-checking bench for digit_buffer (DIGITS=4, DIGIT_W=4). Two instances,
// one per overflow policy, share the same stimulus. A queue-based model of
// the entered digit string supplies every expected value.
module tb_digit_buffer;
    import digit_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = '0;
    logic       valid = 1'b0;
    logic       back = 1'b0;
    logic       clear = 1'b0;

    logic [15:0] out_r, out_s;
    logic [3:0]  mask_r, mask_s;
    logic [2:0]  count_r, count_s;
    logic        full_r, full_s, acc_r, acc_s, ovf_r, ovf_s;

    digit_buffer #(.DIGITS(4), .DIGIT_W(4), .OVERFLOW_MODE(OVF_REJECT)) u_rej (
        .clk(clk), .reset(reset), .digit(digit), .valid(valid), .back(back),
        .clear(clear), .out(out_r), .digit_mask(mask_r), .count(count_r),
        .full(full_r), .accept(acc_r), .overflow(ovf_r)
    );

    digit_buffer #(.DIGITS(4), .DIGIT_W(4), .OVERFLOW_MODE(OVF_SHIFT)) u_sh (
        .clk(clk), .reset(reset), .digit(digit), .valid(valid), .back(back),
        .clear(clear), .out(out_s), .digit_mask(mask_s), .count(count_s),
        .full(full_s), .accept(acc_s), .overflow(ovf_s)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: digit strings, oldest first.
    int   q_rej[$];
    int   q_sh[$];
    logic prev_v = 1'b0;
    logic prev_b = 1'b0;
    logic e_acc_r, e_ovf_r, e_acc_s, e_ovf_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack(input int q[$]);
        logic [15:0] v = '0;
        foreach (q[i]) v = {v[11:0], 4'(q[i])};
        return v;
    endfunction

    function automatic logic [3:0] mask_of(input int n);
        return 4'((1 << n) - 1);
    endfunction

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic cycle(input logic r, input logic c, input logic b,
                         input logic v, input logic [3:0] d);
        logic ve, be;
        reset = r; clear = c; back = b; valid = v; digit = d;
        @(posedge clk);
        ve = v & ~prev_v;
        be = b & ~prev_b;
        prev_v = r ? 1'b0 : v;
        prev_b = r ? 1'b0 : b;
        e_acc_r = 1'b0; e_ovf_r = 1'b0; e_acc_s = 1'b0; e_ovf_s = 1'b0;
        if (r || c) begin
            q_rej.delete();
            q_sh.delete();
        end else if (be) begin
            if (q_rej.size() > 0) void'(q_rej.pop_back());
            if (q_sh.size() > 0)  void'(q_sh.pop_back());
        end else if (ve) begin
            if (q_rej.size() < 4) begin
                q_rej.push_back(int'(d)); e_acc_r = 1'b1;
            end else begin
                e_ovf_r = 1'b1;
            end
            if (q_sh.size() < 4) begin
                q_sh.push_back(int'(d)); e_acc_s = 1'b1;
            end else begin
                void'(q_sh.pop_front());
                q_sh.push_back(int'(d));
                e_acc_s = 1'b1; e_ovf_s = 1'b1;
            end
        end
        #1;
        chk("rej_out",   32'(out_r),   32'(pack(q_rej)));
        chk("rej_count", 32'(count_r), 32'(q_rej.size()));
        chk("rej_mask",  32'(mask_r),  32'(mask_of(q_rej.size())));
        chk("rej_full",  32'(full_r),  32'(q_rej.size() == 4));
        chk("rej_acc",   32'(acc_r),   32'(e_acc_r));
        chk("rej_ovf",   32'(ovf_r),   32'(e_ovf_r));
        chk("sh_out",    32'(out_s),   32'(pack(q_sh)));
        chk("sh_count",  32'(count_s), 32'(q_sh.size()));
        chk("sh_mask",   32'(mask_s),  32'(mask_of(q_sh.size())));
        chk("sh_full",   32'(full_s),  32'(q_sh.size() == 4));
        chk("sh_acc",    32'(acc_s),   32'(e_acc_s));
        chk("sh_ovf",    32'(ovf_s),   32'(e_ovf_s));
    endtask

    // Single-cycle valid pulse followed by one low cycle.
    task automatic enter(input logic [3:0] d);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, d);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic backspace();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        // Reset for two cycles.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("reset_out", 32'(out_r), 32'h0);
        chk("reset_mask", 32'(mask_r), 32'h0);

        // Fill with 9, B, 3, D.
        enter(4'h9); enter(4'hB); enter(4'h3); enter(4'hD);
        chk("fill_out", 32'(out_r), 32'h9B3D);
        chk("fill_full", 32'(full_s), 32'h1);

        // Overflow with digit 1.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
        chk("ovf_rej_out", 32'(out_r), 32'h9B3D);
        chk("ovf_sh_out", 32'(out_s), 32'hB3D1);
        chk("ovf_rej_pulse", 32'({acc_r, ovf_r}), 32'h1);
        chk("ovf_sh_pulse", 32'({acc_s, ovf_s}), 32'h3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h1);

        // Held strobe: digit 7 for five cycles from empty.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h7);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h7);
        chk("held_out", 32'(out_r), 32'h0007);
        chk("held_count", 32'(count_r), 32'h1);

        // Backspace from 0x09B3.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        enter(4'h9); enter(4'hB); enter(4'h3);
        chk("bs_start", 32'(out_r), 32'h09B3);
        backspace();
        chk("bs_out", 32'(out_r), 32'h009B);
        chk("bs_count", 32'(count_r), 32'h2);
        backspace(); backspace(); backspace();
        chk("bs_empty", 32'(out_s), 32'h0);

        // Back and valid rising together: only the backspace happens.
        enter(4'h5);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
        chk("bs_vs_valid", 32'(count_r), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Clear with a valid edge carrying F.
        enter(4'h2);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        chk("clr_out", 32'(out_r), 32'h0);
        chk("clr_acc", 32'(acc_r), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Reset after two digits, with valid still high as reset drops.
        enter(4'h4); enter(4'h8);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
        chk("rst_out", 32'(out_s), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
        chk("post_rst_evt", 32'(out_r), 32'h000C);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 5) == 0,
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_buffer.md
# digit_buffer

Parametrised keypad digit-entry buffer for the security device. Collects debounced keypad digits into a right-justified shift register for the display and code-compare logic. Adds configurable depth and digit width, selectable overflow policy, backspace, and rising-edge qualification of strobes. Sits between the keypad decoder and the seven-segment driver / code comparator.

## Interface
Parameters:
- `DIGITS`, 4: buffer depth in digits (≥2).
- `DIGIT_W`, 4: bits per digit.
- `OVERFLOW_MODE`, `OVF_REJECT`: `OVF_REJECT` drops new digits when full; `OVF_SHIFT` discards the oldest digit.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `digit`  in  DIGIT_W  keypad digit code; sampled with `valid`.
- `valid`  in  1  digit strobe (level, edge-qualified internally).
- `back`  in  1  backspace strobe (level, edge-qualified internally).
- `clear`  in  1  level; empties buffer every cycle it is high.
- `out`  out  DIGITS*DIGIT_W  packed digits; newest in least significant slot.
- `digit_mask`  out  DIGITS  thermometer mask of occupied slots (bit i = slot i valid).
- `count`  out  $clog2(DIGITS+1)  occupied digits.
- `full`  out  1  `count == DIGITS`.
- `accept`  out  1  one-cycle pulse: digit stored in the preceding edge.
- `overflow`  out  1  one-cycle pulse: digit arrived while full.

## Operation
- Rising edge of a strobe means high this cycle and low last cycle. A held strobe yields exactly one event. Edge registers reset to 0. They update every cycle, including cycles with `clear` high.
- Per-cycle priority is `reset` > `clear` > back edge > valid edge. Only one action is taken per cycle. Lower-priority edges in the same cycle are consumed and dropped.
- **Digit event, not full:** `out <= {out[(DIGITS-1)*DIGIT_W-1:0], digit}`, `count++`, `accept` pulses.
- **Digit event, full, `OVF_REJECT`:** contents unchanged, `overflow` pulses, no `accept`.
- **Digit event, full, `OVF_SHIFT`:** oldest digit is shifted out and the new digit shifted in. `count` stays `DIGITS`. Both `accept` and `overflow` pulse.
- **Back event, count > 0:** `out <= out >> DIGIT_W` (zero-filled), `count--`.
- **Back event, empty:** no-op, no pulses.
- **clear:** `out`, `count` ← 0. Pulses are low.
- **Derived outputs:** `digit_mask = (1 << count) - 1`. `full = (count == DIGITS)`. Both are combinational from `count`.
- Unoccupied slots always read 0.

## Timing
- Reset values: `out`=0, `count`=0, `digit_mask`=0, `full`=0, `accept`=0, `overflow`=0.
- Latency: a strobe rising at edge N (first high sample) updates `out` and `count`, and asserts pulses, after edge N. Effect is visible for the cycle following N.
- `accept` and `overflow` are registered and high for exactly one cycle per event.
- Back-to-back single-cycle `valid` pulses separated by one low cycle are each accepted; the minimum event spacing is 2 cycles.
- Reset mid-entry: contents are lost and edge history is cleared. A `valid` still high when `reset` drops counts as an event on the first post-reset cycle.

## Structure
- Package `digit_pkg`:
  - `overflow_mode_e` (`OVF_REJECT`, `OVF_SHIFT`).
  - Shared `DIGIT_W` default constant used by the keypad decoder and display driver.
- Sub-module `edge_detect` (1-bit rising-edge detector, synchronous reset), instantiated for `valid` and `back`.
- Remaining logic (shift register, counter, priority mux, pulse registers) lives in `digit_buffer`.

## Test plan
All scenarios use defaults: DIGITS=4, DIGIT_W=4.
1. **Reset:** assert `reset` 2 cycles → `out`=0x0000, `digit_mask`=0000, `count`=0, `full`=0, no pulses.
2. **Fill:** enter 9, B, 3, D as 1-cycle `valid` pulses → `out`=0x9B3D, `digit_mask`=1111, `full`=1, four `accept` pulses.
3. **Overflow on full buffer:** enter 1. With `OVF_REJECT` → `out` stays 0x9B3D, one `overflow` pulse, no `accept`. With `OVF_SHIFT` → `out`=0xB3D1, both pulses.
4. **Held strobe:** hold `valid` 5 cycles with digit 7, starting empty → `out`=0x0007, `count`=1, single `accept`.
5. **Backspace:** from 0x09B3 (count 3), pulse `back` → `out`=0x009B, count 2.
   - Pulse `back` 3 more times → 0x0000, count 0, final back is a no-op with no pulses.
   - `back` and `valid` rising in the same cycle → only the backspace occurs.
6. **Clear and reset collisions:**
   - `clear` and a `valid` edge with digit F in the same cycle → `out`=0, count 0, no `accept`.
   - `reset` asserted after two digits → all outputs 0 next cycle.
